frame_ddr_writer: RTL

- Parametrised successor to the single-burst frame saver. Packs N-bit pixels into 32-bit words and buffers them in an internal FWFT FIFO.
- Drains the FIFO to PS DDR through the pkg_wr burst interface, using a configurable burst length.
- Rotates frames through NUM_BUF frame buffers and flushes the partial last burst at end of frame.
- Reports completion, buffer index and overflow to the PS (via EMIO/registers).

---
 rtl/frame_ddr_writer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_ddr_writer.sv
// frame_ddr_writer
//   Packs PIX_W-bit pixels two per 32-bit word into an internal first-word-
//   fall-through FIFO and drains it to PS DDR in bursts on the pkg_wr
//   interface. Each frame goes to the next buffer of a NUM_BUF ring. The
//   partial last burst is flushed at end of frame.
// Ports:
//   clk_100m, rst_n             clock, async active-low reset
//   enable                      capture enable, sampled at frame start
//   pix, data_valid             pixel stream
//   frame_valid                 high for the whole frame
//   pkg_wr_addr/areq/size       burst request (byte address, word count)
//   pkg_wr_data                 FIFO head word, consumed by pkg_wr_en
//   pkg_wr_en, pkg_wr_last      controller pop strobe, final beat of burst
//   frame_done/err, buf_idx     per-frame completion report
//   frame_cnt                   completed frame counter
//   overflow                    sticky FIFO overflow flag
module frame_ddr_writer #(
  parameter int          PIX_W       = 12,
  parameter int          BURST_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 2048,
  parameter logic [31:0] DDR_BASE    = 32'd62914560,
  parameter logic [31:0] BUF_STRIDE  = 32'd8388608,
  parameter int          NUM_BUF     = 2
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PIX_W-1:0] pix,
  input  logic             data_valid,
  input  logic             frame_valid,
  output logic [31:0]      pkg_wr_addr,
  output logic             pkg_wr_areq,
  output logic [31:0]      pkg_wr_size,
  output logic [31:0]      pkg_wr_data,
  input  logic             pkg_wr_en,
  input  logic             pkg_wr_last,
  output logic             frame_done,
  output logic             frame_err,
  output logic [1:0]       buf_idx,
  output logic [15:0]      frame_cnt,
  output logic             overflow
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] BURST_CNT = (AW+1)'(BURST_WORDS);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] MAX_WORDS = BUF_STRIDE >> 2;
  localparam logic [1:0]  LAST_BUF  = 2'(NUM_BUF - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_REQ, S_XFER, S_DONE} state_t;

  state_t      state_r;
  logic        fv_d_r;
  logic        capturing_r;
  logic        ended_r;
  logic        half_r;
  logic        push_r;
  logic        err_r;
  logic [15:0] lo_r;
  logic [31:0] push_word_r;
  logic [31:0] words_r;
  logic [1:0]  cur_buf_r;
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [31:0] mem_r [FIFO_DEPTH];

  logic [15:0] pix_lane_s;
  logic        start_s;
  logic        fall_s;
  logic        cap_s;
  logic [AW:0] count_s;
  logic        full_s;
  logic        empty_s;
  logic        limit_s;
  logic        wr_ok_s;
  logic        pop_s;
  logic        flushed_s;

  assign pix_lane_s = 16'(pix);
  // A frame only starts from IDLE, so a rising edge during an active frame is ignored.
  assign start_s    = frame_valid & ~fv_d_r & enable & (state_r == S_IDLE);
  assign fall_s     = ~frame_valid & fv_d_r;
  // Pixels arriving on the start cycle itself belong to the new frame.
  assign cap_s      = (capturing_r | start_s) & frame_valid & data_valid;
  assign count_s    = wr_ptr_r - rd_ptr_r;
  assign full_s     = (count_s == DEPTH_CNT);
  assign empty_s    = (count_s == {(AW+1){1'b0}});
  assign limit_s    = (words_r >= MAX_WORDS);
  assign wr_ok_s    = push_r & ~full_s & ~limit_s;
  assign pop_s      = (state_r == S_XFER) & pkg_wr_en & ~empty_s;
  // The final half word is still in push_r the cycle after the falling edge.
  assign flushed_s  = ended_r & ~push_r;
  assign pkg_wr_data = mem_r[rd_ptr_r[AW-1:0]];

  // FIFO storage write port (no reset, contents qualified by the pointers)
  always_ff @(posedge clk_100m) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_word_r;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  // Frame tracking, pixel packer, FIFO pointers and drop/overflow flags
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      fv_d_r      <= 1'b0;
      capturing_r <= 1'b0;
      ended_r     <= 1'b0;
      half_r      <= 1'b0;
      push_r      <= 1'b0;
      err_r       <= 1'b0;
      lo_r        <= 16'h0000;
      push_word_r <= 32'h0000_0000;
      words_r     <= 32'd0;
      wr_ptr_r    <= {(AW+1){1'b0}};
      rd_ptr_r    <= {(AW+1){1'b0}};
      overflow    <= 1'b0;
    end else begin
      fv_d_r <= frame_valid;
      push_r <= 1'b0;

      if (start_s) begin
        capturing_r <= 1'b1;
        ended_r     <= 1'b0;
        words_r     <= 32'd0;
        err_r       <= 1'b0;
      end else if (fall_s && capturing_r) begin
        capturing_r <= 1'b0;
        ended_r     <= 1'b1;
      end else begin
        capturing_r <= capturing_r;
      end

      if (cap_s) begin
        if (half_r && !start_s) begin
          push_word_r <= {pix_lane_s, lo_r};
          push_r      <= 1'b1;
          half_r      <= 1'b0;
        end else begin
          lo_r   <= pix_lane_s;
          half_r <= 1'b1;
        end
      end else if (start_s) begin
        half_r <= 1'b0;
      end else if (fall_s && capturing_r && half_r) begin
        push_word_r <= {16'h0000, lo_r};
        push_r      <= 1'b1;
        half_r      <= 1'b0;
      end else begin
        half_r <= half_r;
      end

      // Drops: the frame limit keeps the address inside its buffer; a full FIFO is an overflow.
      if (push_r) begin
        if (limit_s) begin
          err_r <= 1'b1;
        end else if (full_s) begin
          err_r    <= 1'b1;
          overflow <= 1'b1;
        end else begin
          wr_ptr_r <= wr_ptr_r + 1'b1;
          words_r  <= words_r + 32'd1;
        end
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end

      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Burst sequencing FSM with registered request and completion outputs
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      pkg_wr_areq <= 1'b0;
      pkg_wr_addr <= DDR_BASE;
      pkg_wr_size <= 32'(BURST_WORDS);
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      buf_idx     <= 2'd0;
      frame_cnt   <= 16'd0;
      cur_buf_r   <= 2'd0;
    end else begin
      pkg_wr_areq <= 1'b0;
      frame_done  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            pkg_wr_addr <= DDR_BASE + BUF_STRIDE * {30'd0, cur_buf_r};
            state_r     <= S_ARM;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ARM: begin
          if (count_s >= BURST_CNT) begin
            pkg_wr_size <= 32'(BURST_WORDS);
            pkg_wr_areq <= 1'b1;
            state_r     <= S_REQ;
          end else if (flushed_s && !empty_s) begin
            pkg_wr_size <= 32'(count_s);
            pkg_wr_areq <= 1'b1;
            state_r     <= S_REQ;
          end else if (flushed_s) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_ARM;
          end
        end
        S_REQ: begin
          state_r <= S_XFER;
        end
        S_XFER: begin
          if (pkg_wr_en && pkg_wr_last) begin
            pkg_wr_addr <= pkg_wr_addr + (pkg_wr_size << 2);
            state_r     <= S_ARM;
          end else begin
            state_r <= S_XFER;
          end
        end
        S_DONE: begin
          frame_done <= 1'b1;
          frame_err  <= err_r;
          buf_idx    <= cur_buf_r;
          frame_cnt  <= frame_cnt + 16'd1;
          cur_buf_r  <= (cur_buf_r == LAST_BUF) ? 2'd0 : cur_buf_r + 2'd1;
          state_r    <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
